// File: rtl/uart_rx_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_controller_pkg
// Description : Shared UART rate selection, divisor table and RX FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_controller_pkg;

    typedef enum logic [1:0] {
        BAUD_9600   = 2'd0,
        BAUD_19200  = 2'd1,
        BAUD_57600  = 2'd2,
        BAUD_115200 = 2'd3
    } baud_set_t;

    localparam int c_DIV_W = 7;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Cycles per oversample tick at a 16 MHz clock.
    function automatic logic [c_DIV_W-1:0] baud_div(input baud_set_t sel);
        logic [c_DIV_W-1:0] div;
        case (sel)
            BAUD_9600:   div = 7'd104;
            BAUD_19200:  div = 7'd52;
            BAUD_57600:  div = 7'd17;
            BAUD_115200: div = 7'd9;
            default:     div = 7'd104;
        endcase
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_tick_gen
// Description : Oversample tick generator with synchronous restart and index.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_tick_gen
    import uart_rx_controller_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_restart,
    input  logic [c_DIV_W-1:0]            i_div,
    output logic                          o_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_tick_idx
);

    localparam int c_IDX_W = $clog2(OVERSAMPLE);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(OVERSAMPLE - 1);

    logic [c_DIV_W-1:0] r_cnt_q;
    logic [c_DIV_W-1:0] w_cnt_d;
    logic [c_IDX_W-1:0] r_idx_q;
    logic [c_IDX_W-1:0] w_idx_d;
    logic               w_wrap;

    always_comb begin
        w_wrap  = (r_cnt_q == '0);
        w_cnt_d = r_cnt_q - c_DIV_W'(1);
        w_idx_d = r_idx_q;
        if (i_restart) begin
            w_cnt_d = i_div - c_DIV_W'(1);
            w_idx_d = '0;
        end else if (w_wrap) begin
            w_cnt_d = i_div - c_DIV_W'(1);
            w_idx_d = (r_idx_q == c_IDX_LAST) ? '0 : r_idx_q + c_IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
            r_idx_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
            r_idx_q <= w_idx_d;
        end
    end

    // A restart swallows a coincident wrap so the new bit timeline starts clean.
    assign o_tick     = w_wrap && !i_restart;
    assign o_tick_idx = r_idx_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_controller
// Description : 8N1 UART receiver, 16x oversampled, majority vote, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int F_CLK      = 16000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk_16mhz,
    input  logic                  rst,
    input  logic                  serial_in,
    input  baud_set_t             baud_setting,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  rx_busy
);

    localparam int c_IDX_W = $clog2(OVERSAMPLE);
    localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_IDX_W-1:0] c_SAMP0_IDX = c_IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_IDX_W-1:0] c_SAMP1_IDX = c_IDX_W'(OVERSAMPLE / 2);
    localparam logic [c_IDX_W-1:0] c_VOTE_IDX  = c_IDX_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(OVERSAMPLE - 1);
    localparam logic [c_CNT_W-1:0] c_BITS      = c_CNT_W'(DATA_WIDTH);
    localparam logic [1:0]         c_SETTLED   = 2'd2;

    if (F_CLK != 16000000 || OVERSAMPLE < 10) begin : g_param_check
        $error("uart_rx_controller: divisor table requires F_CLK=16 MHz and OVERSAMPLE>=10");
    end

    logic                  r_sync1_q, w_sync1_d;
    logic                  r_sync2_q, w_sync2_d;
    logic                  r_prev_q, w_prev_d;
    logic [1:0]            r_settle_q, w_settle_d;
    rx_state_t             r_state_q, w_state_d;
    baud_set_t             r_baud_q, w_baud_d;
    logic [1:0]            r_samp_q, w_samp_d;
    logic [DATA_WIDTH-1:0] r_shift_q, w_shift_d;
    logic [DATA_WIDTH-1:0] r_data_q, w_data_d;
    logic [c_CNT_W-1:0]    r_bit_cnt_q, w_bit_cnt_d;
    logic                  r_valid_q, w_valid_d;
    logic                  r_ferr_q, w_ferr_d;
    logic                  r_oerr_q, w_oerr_d;
    logic                  r_busy_q, w_busy_d;

    logic                  w_line;
    logic                  w_start_edge;
    logic [c_DIV_W-1:0]    w_div;
    logic                  w_tick;
    logic [c_IDX_W-1:0]    w_tick_idx;
    logic                  w_vote_now;
    logic                  w_vote_bit;
    logic                  w_tick_end;
    logic                  w_deliver;

    assign w_line       = r_sync2_q;
    assign w_start_edge = (r_state_q == RX_IDLE) && r_prev_q && !w_line;
    // The divisor must track the new selection in the very cycle it is latched.
    assign w_div        = w_start_edge ? baud_div(baud_setting) : baud_div(r_baud_q);

    uart_rx_tick_gen #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk        (clk_16mhz),
        .rst        (rst),
        .i_restart  (w_start_edge),
        .i_div      (w_div),
        .o_tick     (w_tick),
        .o_tick_idx (w_tick_idx)
    );

    always_comb begin
        w_sync1_d   = serial_in;
        w_sync2_d   = r_sync1_q;
        w_settle_d  = (r_settle_q == c_SETTLED) ? r_settle_q : r_settle_q + 2'd1;
        // Edge history stays low until the synchronizer holds real line data,
        // so a line already low out of reset never looks like a start edge.
        w_prev_d    = (r_settle_q == c_SETTLED) && w_line;

        w_vote_now  = w_tick && (w_tick_idx == c_VOTE_IDX);
        w_tick_end  = w_tick && (w_tick_idx == c_IDX_LAST);
        w_vote_bit  = (r_samp_q[0] & r_samp_q[1]) | (r_samp_q[0] & w_line) |
                      (r_samp_q[1] & w_line);

        w_samp_d    = r_samp_q;
        if (w_tick && (w_tick_idx == c_SAMP0_IDX)) w_samp_d[0] = w_line;
        if (w_tick && (w_tick_idx == c_SAMP1_IDX)) w_samp_d[1] = w_line;

        w_state_d   = r_state_q;
        w_baud_d    = r_baud_q;
        w_shift_d   = r_shift_q;
        w_bit_cnt_d = r_bit_cnt_q;
        w_busy_d    = r_busy_q;
        w_ferr_d    = 1'b0;
        w_oerr_d    = 1'b0;
        w_deliver   = 1'b0;

        case (r_state_q)
            RX_IDLE: begin
                if (w_start_edge) begin
                    w_state_d = RX_START;
                    w_baud_d  = baud_setting;
                    w_busy_d  = 1'b1;
                end
            end
            RX_START: begin
                if (w_vote_now && w_vote_bit) begin
                    w_state_d = RX_IDLE;
                    w_busy_d  = 1'b0;
                end else if (w_tick_end) begin
                    w_state_d   = RX_DATA;
                    w_bit_cnt_d = '0;
                end
            end
            RX_DATA: begin
                if (w_vote_now) begin
                    w_shift_d   = {w_vote_bit, r_shift_q[DATA_WIDTH-1:1]};
                    w_bit_cnt_d = r_bit_cnt_q + c_CNT_W'(1);
                end else if (w_tick_end && (r_bit_cnt_q == c_BITS)) begin
                    w_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Leave at the vote so a start edge right after stop is caught.
                if (w_vote_now) begin
                    w_busy_d = 1'b0;
                    if (w_vote_bit) begin
                        w_deliver = 1'b1;
                        w_state_d = RX_IDLE;
                    end else begin
                        w_ferr_d  = 1'b1;
                        w_state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (w_line) w_state_d = RX_IDLE;
            end
            default: begin
                w_state_d = RX_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase

        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        if (r_valid_q && rx_ready) w_valid_d = 1'b0;
        if (w_deliver) begin
            if (!r_valid_q || rx_ready) begin
                w_data_d  = r_shift_q;
                w_valid_d = 1'b1;
            end else begin
                w_oerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            r_sync1_q   <= 1'b1;
            r_sync2_q   <= 1'b1;
            r_prev_q    <= 1'b0;
            r_settle_q  <= 2'd0;
            r_state_q   <= RX_IDLE;
            r_baud_q    <= BAUD_9600;
            r_samp_q    <= 2'b00;
            r_shift_q   <= '0;
            r_data_q    <= '0;
            r_bit_cnt_q <= '0;
            r_valid_q   <= 1'b0;
            r_ferr_q    <= 1'b0;
            r_oerr_q    <= 1'b0;
            r_busy_q    <= 1'b0;
        end else begin
            r_sync1_q   <= w_sync1_d;
            r_sync2_q   <= w_sync2_d;
            r_prev_q    <= w_prev_d;
            r_settle_q  <= w_settle_d;
            r_state_q   <= w_state_d;
            r_baud_q    <= w_baud_d;
            r_samp_q    <= w_samp_d;
            r_shift_q   <= w_shift_d;
            r_data_q    <= w_data_d;
            r_bit_cnt_q <= w_bit_cnt_d;
            r_valid_q   <= w_valid_d;
            r_ferr_q    <= w_ferr_d;
            r_oerr_q    <= w_oerr_d;
            r_busy_q    <= w_busy_d;
        end
    end

    assign rx_data     = r_data_q;
    assign rx_valid    = r_valid_q;
    assign frame_err   = r_ferr_q;
    assign overrun_err = r_oerr_q;
    assign rx_busy     = r_busy_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Serial receiver that consumes the line driven by the UART TX path (looped back or external) and delivers parallel bytes to the core over a valid/ready interface. Oversamples the line at 16x the selected baud, majority-votes each bit at mid-period, and checks the stop bit. Shares the baud_set_t selection used by the TX side so both directions run at the same rate.

Parameters:
DATA_WIDTH, 8, data bits per frame (8N1 framing: 1 start, DATA_WIDTH data LSB-first, 1 stop)
F_CLK, 16000000, clk_16mhz frequency in Hz; divisor table in package assumes this value
OVERSAMPLE, 16, oversample ticks per bit

Ports:
clk_16mhz  input  1  system clock
rst  input  1  synchronous, active-high reset
serial_in  input  1  asynchronous RX line, idle high
baud_setting  input  baud_set_t  rate select; latched at start detect
rx_data  output  DATA_WIDTH  received byte, stable while rx_valid=1
rx_valid  output  1  byte available; held until accepted
rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun_err  output  1  one-cycle pulse: frame completed while rx_valid still high
rx_busy  output  1  high from start detect until frame end/abort

Behaviour:
- Reset: one clock and one reset only; reset is synchronous and active-high. rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, rx_busy=0, FSM=IDLE, synchronizer flops=1.
- Input sync: 2-flop synchronizer on serial_in, reset value 1. All logic uses synced line (2-cycle latency).
- Tick gen: counter reloads to divisor-1 on start detect, emits 1-cycle tick at wrap. Divisor = baud_div(baud_latched): BAUD_9600=104, BAUD_19200=52, BAUD_57600=17, BAUD_115200=9. Bit period = 16*divisor cycles.
- Per-bit tick index 0..15. Samples at ticks 7, 8, 9; bit value = majority of 3, decided at tick 9.
- FSM:
  IDLE: falling edge of synced line (1 -> 0) -> START; latch baud_setting; rx_busy=1.
  START: voted value 1 -> IDLE (glitch reject, no error, rx_busy=0); 0 -> DATA at tick 15.
  DATA: shift voted bit into shift reg LSB-first; after DATA_WIDTH bits -> STOP at tick 15.
  STOP: at vote (tick 9): 1 -> deliver, go IDLE; 0 -> frame_err pulse, byte discarded, go BREAK. No wait for tick 15 so a back-to-back start edge is caught.
  BREAK: wait until synced line = 1, then IDLE (no start detect while low).
- Delivery: cycle after stop vote, if rx_valid=0 -> rx_data=shift reg, rx_valid=1. If rx_valid=1 and not accepted that same cycle -> new byte dropped, old rx_data kept, overrun_err pulse. Accept and delivery in same cycle -> new byte loaded, rx_valid stays 1, no overrun.
- rx_valid clears the cycle after rx_valid && rx_ready.
- baud_setting changes mid-frame ignored until next start detect.
- Reset mid-frame: FSM to IDLE immediately; partial byte lost; a line still low after reset does not trigger start until a fresh 1 -> 0 edge.
- Error pulses mutually exclusive; exactly one cycle each.

Decomposition:
- Shared package (extend baud_setting.svh): baud_set_t enum and baud_div() function returning the divisor table; rx FSM state enum (IDLE, START, DATA, STOP, BREAK).
- One sub-module: uart_rx_tick_gen (divisor counter with sync restart; outputs tick and 4-bit tick index).

Test Plan:
- Reset: rst=1 for 3 cycles with serial_in=1 -> all outputs 0; rx_busy=0.
- BAUD_115200 (144 cycles/bit), send 0xA5, rx_ready=1 -> rx_valid high exactly 1 cycle with rx_data=0xA5; no error pulses.
- Glitch: serial_in low 40 cycles then high (BAUD_115200) -> no rx_valid, no frame_err; rx_busy returns 0 within 1 bit period.
- Frame error: send 0x3C with stop bit=0, then hold line low 500 cycles -> single frame_err pulse, no rx_valid, no new frame while low; line high then send 0x55 -> rx_data=0x55.
- Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid=1 with 0x11 held; overrun_err pulse after second stop vote; then rx_ready=1 -> rx_valid=0 next cycle.
- Back-to-back at BAUD_9600 with bit period stretched +2% (1698 cycles/bit), send 0x00, 0xFF, 0x81 -> all three received in order; assert rst mid-0xFF on a rerun -> FSM returns to IDLE, no partial byte delivered.
